// File: rtl/cphy_rx_hs_seq_if.sv
// Signal bundle linking the C-PHY symbol decoder, the HS receive sequencer
// and the word-rate PPI logic.
interface cphy_rx_hs_seq_if;
    logic        HsEn;
    logic [2:0]  Symbol;
    logic        SymValid;
    logic        WordClkEn;
    logic        WordClkSync;
    logic [20:0] RxDataHs;
    logic        RxValidHs;
    logic        RxActiveHs;
    logic        RxSyncHs;
    logic        ErrSyncHs;

    modport master (
        output HsEn, Symbol, SymValid,
        input  WordClkEn, WordClkSync, RxDataHs, RxValidHs, RxActiveHs, RxSyncHs, ErrSyncHs
    );

    modport slave (
        input  HsEn, Symbol, SymValid,
        output WordClkEn, WordClkSync, RxDataHs, RxValidHs, RxActiveHs, RxSyncHs, ErrSyncHs
    );
endinterface

// File: rtl/cphy_rx_hs_seq.sv
// C-PHY HS receive sequencer: settle, preamble qualification, sync hunt,
// and packing of seven 3-bit symbols into 21-bit words.
module cphy_rx_hs_seq #(
    parameter int SETTLE_CYC   = 8,
    parameter int MIN_PREAMBLE = 14,
    parameter int HUNT_TIMEOUT = 64
) (
    input  logic            SymClk,
    input  logic            RST,
    cphy_rx_hs_seq_if.slave bus
);
    localparam logic [20:0] SYNC_WORD = 21'o3444443;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PREAMBLE,
        ST_SYNC_HUNT,
        ST_ACTIVE,
        ST_WAIT_EXIT
    } state_t;

    state_t      state_reg;
    logic [7:0]  settle_cnt_reg;
    logic [7:0]  pre_cnt_reg;
    logic [7:0]  hunt_cnt_reg;
    logic [20:0] hist_reg;
    logic [20:0] word_reg;
    logic [20:0] rx_data_reg;
    logic [2:0]  phase_reg;
    logic        word_clk_en_reg;
    logic        word_clk_sync_reg;
    logic        rx_valid_reg;
    logic        rx_active_reg;
    logic        rx_sync_reg;
    logic        err_sync_reg;

    logic [7:0]  pre_cnt_next;
    logic [7:0]  hunt_cnt_next;
    logic [20:0] hist_next;
    logic [20:0] word_next;
    logic        sync_match;

    // Preamble run length saturates so a long preamble never wraps back below the threshold.
    assign pre_cnt_next  = (bus.Symbol != 3'd3)   ? 8'd0  :
                           (pre_cnt_reg == 8'hFF) ? 8'hFF : pre_cnt_reg + 8'd1;
    assign hunt_cnt_next = hunt_cnt_reg + 8'd1;
    assign hist_next     = {hist_reg[17:0], bus.Symbol};
    assign sync_match    = (hist_next == SYNC_WORD);

    // Slot 0 holds the first symbol of the word in the top bits.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_slot
            assign word_next[20-3*gi -: 3] = (phase_reg == 3'(gi)) ? bus.Symbol
                                                                   : word_reg[20-3*gi -: 3];
        end
    endgenerate

    always_ff @(posedge SymClk or negedge RST) begin
        if (!RST) begin
            state_reg         <= ST_IDLE;
            settle_cnt_reg    <= 8'd0;
            pre_cnt_reg       <= 8'd0;
            hunt_cnt_reg      <= 8'd0;
            hist_reg          <= 21'd0;
            word_reg          <= 21'd0;
            rx_data_reg       <= 21'd0;
            phase_reg         <= 3'd0;
            word_clk_en_reg   <= 1'b0;
            word_clk_sync_reg <= 1'b0;
            rx_valid_reg      <= 1'b0;
            rx_active_reg     <= 1'b0;
            rx_sync_reg       <= 1'b0;
            err_sync_reg      <= 1'b0;
        end else begin
            word_clk_sync_reg <= 1'b0;
            rx_valid_reg      <= 1'b0;
            rx_sync_reg       <= 1'b0;
            err_sync_reg      <= 1'b0;

            if (!bus.HsEn) begin
                // Lane disable overrides everything; a partial word is thrown away.
                state_reg       <= ST_IDLE;
                word_clk_en_reg <= 1'b0;
                rx_active_reg   <= 1'b0;
                settle_cnt_reg  <= 8'd0;
                pre_cnt_reg     <= 8'd0;
                hunt_cnt_reg    <= 8'd0;
                hist_reg        <= 21'd0;
                word_reg        <= 21'd0;
                phase_reg       <= 3'd0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg      <= ST_SETTLE;
                        settle_cnt_reg <= 8'(SETTLE_CYC - 1);
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_reg == 8'd0) begin
                            state_reg   <= ST_PREAMBLE;
                            pre_cnt_reg <= 8'd0;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg - 8'd1;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (bus.SymValid) begin
                            pre_cnt_reg <= pre_cnt_next;
                            if (pre_cnt_next >= 8'(MIN_PREAMBLE)) begin
                                state_reg    <= ST_SYNC_HUNT;
                                hunt_cnt_reg <= 8'd0;
                                hist_reg     <= 21'd0;
                            end
                        end
                    end
                    ST_SYNC_HUNT: begin
                        if (bus.SymValid) begin
                            hist_reg     <= hist_next;
                            hunt_cnt_reg <= hunt_cnt_next;
                            // A match on the timeout symbol still counts as a match.
                            if (sync_match) begin
                                state_reg         <= ST_ACTIVE;
                                phase_reg         <= 3'd0;
                                rx_sync_reg       <= 1'b1;
                                word_clk_sync_reg <= 1'b1;
                                word_clk_en_reg   <= 1'b1;
                                rx_active_reg     <= 1'b1;
                            end else if (hunt_cnt_next == 8'(HUNT_TIMEOUT)) begin
                                state_reg    <= ST_WAIT_EXIT;
                                err_sync_reg <= 1'b1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        word_clk_en_reg <= 1'b1;
                        rx_active_reg   <= 1'b1;
                        if (bus.SymValid) begin
                            word_reg <= word_next;
                            if (phase_reg == 3'd6) begin
                                phase_reg    <= 3'd0;
                                rx_data_reg  <= word_next;
                                rx_valid_reg <= 1'b1;
                            end else begin
                                phase_reg <= phase_reg + 3'd1;
                            end
                        end
                    end
                    ST_WAIT_EXIT: begin
                        word_clk_en_reg <= 1'b0;
                        rx_active_reg   <= 1'b0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.WordClkEn   = word_clk_en_reg;
    assign bus.WordClkSync = word_clk_sync_reg;
    assign bus.RxDataHs    = rx_data_reg;
    assign bus.RxValidHs   = rx_valid_reg;
    assign bus.RxActiveHs  = rx_active_reg;
    assign bus.RxSyncHs    = rx_sync_reg;
    assign bus.ErrSyncHs   = err_sync_reg;
endmodule

// File: tb/tb_cphy_rx_hs_seq.sv
// Directed bench for cphy_rx_hs_seq: nominal burst, stalls, broken preamble,
// hunt timeout, mid-word exits and asynchronous reset.
module tb_cphy_rx_hs_seq;
    localparam int SETTLE = 8;

    logic sym_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n_valid  = 0;
    int   n_sync   = 0;
    int   n_wcs    = 0;
    int   n_err    = 0;

    cphy_rx_hs_seq_if bus ();

    cphy_rx_hs_seq #(
        .SETTLE_CYC  (8),
        .MIN_PREAMBLE(14),
        .HUNT_TIMEOUT(64)
    ) dut (
        .SymClk(sym_clk),
        .RST   (rst_n),
        .bus   (bus)
    );

    always #5 sym_clk = ~sym_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("  ok   %s = 0x%0h", tag, got);
        end
    endtask

    // {WordClkEn, WordClkSync, RxValidHs, RxActiveHs, RxSyncHs, ErrSyncHs}
    function automatic logic [31:0] ctrl();
        return {26'd0, bus.WordClkEn, bus.WordClkSync, bus.RxValidHs,
                bus.RxActiveHs, bus.RxSyncHs, bus.ErrSyncHs};
    endfunction

    task automatic step();
        @(posedge sym_clk);
        #1;
        if (bus.RxValidHs)   n_valid++;
        if (bus.RxSyncHs)    n_sync++;
        if (bus.WordClkSync) n_wcs++;
        if (bus.ErrSyncHs)   n_err++;
    endtask

    task automatic send(input logic [2:0] s);
        bus.Symbol   = s;
        bus.SymValid = 1'b1;
        step();
        bus.SymValid = 1'b0;
    endtask

    task automatic send_n(input logic [2:0] s, input int n);
        repeat (n) send(s);
    endtask

    task automatic stall(input int n);
        bus.SymValid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_sync();
        send(3'd3);
        send_n(3'd4, 5);
        send(3'd3);
    endtask

    task automatic start_burst(input logic [2:0] settle_sym, input logic settle_valid);
        bus.HsEn     = 1'b1;
        bus.Symbol   = settle_sym;
        bus.SymValid = settle_valid;
        repeat (1 + SETTLE) step();
        bus.SymValid = 1'b0;
    endtask

    initial begin
        bus.HsEn     = 1'b0;
        bus.Symbol   = 3'd0;
        bus.SymValid = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge sym_clk);
        #1;
        chk("reset_ctrl", ctrl(), 32'd0);
        chk("reset_data", 32'(bus.RxDataHs), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_ctrl", ctrl(), 32'd0);

        // Nominal burst
        start_burst(3'd0, 1'b0);
        chk("settle_ctrl", ctrl(), 32'd0);
        send_n(3'd3, 14);
        send(3'd3);
        send_n(3'd4, 5);
        chk("hunt_ctrl", ctrl(), 32'd0);
        send(3'd3);
        chk("sync_entry", {28'd0, bus.RxSyncHs, bus.WordClkSync, bus.RxActiveHs, bus.WordClkEn}, 32'hF);
        send(3'd0);
        chk("sync_one_cycle", {28'd0, bus.RxSyncHs, bus.WordClkSync, bus.RxActiveHs, bus.WordClkEn}, 32'h3);
        send(3'd1); send(3'd2); send(3'd3); send(3'd4); send(3'd0);
        chk("nom_valid_early", 32'(bus.RxValidHs), 32'd0);
        send(3'd1);
        chk("nom_valid", 32'(bus.RxValidHs), 32'd1);
        chk("nom_data", 32'(bus.RxDataHs), 32'o0123401);
        step();
        chk("nom_valid_pulse", 32'(bus.RxValidHs), 32'd0);
        chk("nom_data_hold", 32'(bus.RxDataHs), 32'o0123401);
        chk("nom_sync_cnt", n_sync, 1);
        chk("nom_wcs_cnt", n_wcs, 1);
        chk("nom_valid_cnt", n_valid, 1);

        // Stalls between data symbols
        send(3'd2); stall(2); send(3'd4); stall(1); send(3'd1); send(3'd3);
        stall(3); send(3'd0); send(3'd2);
        chk("stall_valid_early", 32'(bus.RxValidHs), 32'd0);
        chk("stall_data_hold", 32'(bus.RxDataHs), 32'o0123401);
        send(3'd4);
        chk("stall_valid", 32'(bus.RxValidHs), 32'd1);
        chk("stall_data", 32'(bus.RxDataHs), 32'o2413024);
        stall(1);
        chk("stall_valid_pulse", 32'(bus.RxValidHs), 32'd0);

        // Exit mid-word
        send_n(3'd1, 4);
        bus.HsEn = 1'b0;
        step();
        chk("exit_ctrl", ctrl(), 32'd0);
        chk("exit_data_hold", 32'(bus.RxDataHs), 32'o2413024);
        send_n(3'd1, 3);
        chk("exit_valid_cnt", n_valid, 2);

        // HsEn drops on the edge that would complete a word
        start_burst(3'd0, 1'b0);
        send_n(3'd3, 14);
        send_sync();
        chk("drop_sync_cnt", n_sync, 2);
        send_n(3'd4, 6);
        bus.HsEn = 1'b0;
        send(3'd2);
        chk("drop_ctrl", ctrl(), 32'd0);
        chk("drop_data_hold", 32'(bus.RxDataHs), 32'o2413024);
        chk("drop_valid_cnt", n_valid, 2);

        // Hunt timeout, restarting straight after the drop
        start_burst(3'd3, 1'b1);
        send_n(3'd3, 14);
        send_n(3'd3, 63);
        chk("timeout_early", n_err, 0);
        send(3'd3);
        chk("timeout_err", 32'(bus.ErrSyncHs), 32'd1);
        chk("timeout_clk_en", 32'(bus.WordClkEn), 32'd0);
        send_sync();
        chk("wait_exit_ctrl", ctrl(), 32'd0);
        chk("wait_exit_err_cnt", n_err, 1);
        chk("wait_exit_sync_cnt", n_sync, 2);
        bus.HsEn = 1'b0;
        step();
        chk("timeout_idle_ctrl", ctrl(), 32'd0);

        // Broken preamble
        start_burst(3'd3, 1'b1);
        send_n(3'd3, 10);
        send(3'd2);
        send_n(3'd3, 13);
        send_sync();
        chk("broken_no_sync", n_sync, 2);
        send_sync();
        chk("broken_sync", 32'(bus.RxSyncHs), 32'd1);
        chk("broken_active", 32'(bus.RxActiveHs), 32'd1);

        // Asynchronous reset in ACTIVE
        send(3'd1);
        send(3'd2);
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", ctrl(), 32'd0);
        chk("async_reset_data", 32'(bus.RxDataHs), 32'd0);
        bus.HsEn = 1'b0;
        #3;
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_reset_ctrl", ctrl(), 32'd0);
        chk("post_reset_data", 32'(bus.RxDataHs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cphy_rx_hs_seq.md
Name: cphy_rx_hs_seq

Overview:
HS receive sequencer for the C-PHY slave lane.
- Runs on the symbol clock. Enables and phase-aligns the word clock generator.
- Qualifies the preamble and hunts for the sync word.
- Packs seven received 3-bit symbols into one 21-bit word per word period.
- Sits between the symbol decoder (upstream) and the word-rate PPI logic (downstream).

Parameters:
SETTLE_CYC, 8, SymClk cycles ignored after HsEn rises (range 1..255)
MIN_PREAMBLE, 14, consecutive valid preamble symbols (value 3) required before the sync hunt (range 1..255)
HUNT_TIMEOUT, 64, valid symbols allowed in SYNC_HUNT before a sync error (range 7..255)

Ports:
SymClk  input  1  symbol clock; all logic on posedge
RST  input  1  asynchronous active-low reset
HsEn  input  1  HS receive enable from lane control, level
Symbol  input  3  decoded symbol, 0..4
SymValid  input  1  Symbol is valid this cycle; when low, the cycle is a stall
WordClkEn  output  1  enable to the word clock generator
WordClkSync  output  1  one-cycle pulse that realigns word clock phase
RxDataHs  output  21  packed word; first received symbol in [20:18], last in [2:0]
RxValidHs  output  1  one-cycle pulse, RxDataHs valid
RxActiveHs  output  1  high while in ACTIVE
RxSyncHs  output  1  one-cycle pulse on sync word detect
ErrSyncHs  output  1  one-cycle pulse on hunt timeout

Behaviour:
- Reset (RST low, async): state IDLE; all outputs 0; counters and shift register cleared; RxDataHs = 0.
- "Valid symbol" means SymValid = 1 on a posedge. All symbol counting uses valid symbols only; stall cycles hold all state except the SETTLE countdown.
- HsEn low in any state: go to IDLE on the next edge. Outputs follow the IDLE state, and any partial word is discarded. This has priority over every other transition.
- States:
  - IDLE: on HsEn = 1, go to SETTLE and load the settle counter with SETTLE_CYC-1.
  - SETTLE: decrement every cycle regardless of SymValid. At 0, go to PREAMBLE with the preamble count cleared.
  - PREAMBLE:
    - Valid Symbol == 3: increment the preamble count, saturating at 255.
    - Valid Symbol != 3: clear the preamble count.
    - Preamble count >= MIN_PREAMBLE: go to SYNC_HUNT. The hunt counter and the 7-deep symbol shift register are cleared.
  - SYNC_HUNT:
    - Each valid symbol shifts into the 21-bit history and increments the hunt counter.
    - Match when the last seven valid symbols, oldest to newest, are 3,4,4,4,4,4,3. The match includes the symbol arriving this cycle.
    - On match: go to ACTIVE. RxSyncHs = 1 and WordClkSync = 1 for one cycle, registered, asserted in the first ACTIVE cycle. Symbol phase is cleared to 0.
    - Hunt counter reaches HUNT_TIMEOUT with no match: pulse ErrSyncHs for one cycle and go to WAIT_EXIT.
    - A match and the timeout on the same symbol: the match wins.
  - ACTIVE:
    - WordClkEn = 1 and RxActiveHs = 1.
    - Each valid symbol is written to slot phase (phase 0 -> [20:18]), and phase increments 0..6.
    - On the phase-6 symbol: phase wraps to 0, and the completed word is copied to RxDataHs.
    - RxValidHs pulses in the cycle after that edge. Latency is 1 cycle from the 7th symbol edge to the RxDataHs/RxValidHs output.
    - RxDataHs holds its value until the next word completes.
  - WAIT_EXIT: all outputs 0; stay here until HsEn = 0, then go to IDLE.
- WordClkEn is 0 outside ACTIVE. The word clock generator is held idle between bursts.
- HsEn falling in the same cycle as a word completes: the word is dropped. No RxValidHs pulse.
- HsEn re-asserted immediately after a drop: requires one IDLE cycle, then restarts at SETTLE.
- All outputs are registered.

Test Plan:
- Reset: hold RST low mid-ACTIVE -> all outputs 0 immediately; after release with HsEn = 0, stay in IDLE with all outputs 0.
- Nominal burst (defaults): HsEn = 1, 8 settle cycles, 14 symbols of 3, sync 3,4,4,4,4,4,3, then symbols 0,1,2,3,4,0,1 -> RxSyncHs/WordClkSync pulse once, RxActiveHs = 1, WordClkEn = 1, RxDataHs = 21'o0123401 with a single RxValidHs pulse one cycle after the 7th symbol.
- Stalls: insert SymValid = 0 gaps between data symbols -> identical RxDataHs, and RxValidHs delayed only by the stall count.
- Broken preamble: 10 symbols of 3, one 2, then 13 symbols of 3 -> no transition to SYNC_HUNT; the 14th consecutive 3 enters SYNC_HUNT.
- Hunt timeout: after a valid preamble, send 64 symbols of 3 -> ErrSyncHs pulses once, no RxSyncHs, WordClkEn stays 0; drop HsEn -> IDLE.
- Exit mid-word: in ACTIVE, deliver 4 symbols and drop HsEn -> no RxValidHs, RxActiveHs = 0 next cycle, RxDataHs retains the previous word.
